usb_ep_router: RTL and testbench
================================

// Module: usb_ep_router
// PURPOSE
//  Transaction router/scheduler between TransactionSM and NUM_EP endpoint handlers (EP0 = control handler).
//  Decodes each token, owns the routing state for one transaction at a time, gives the shared byte datapath
//  to exactly one endpoint handler, and returns the handler's ack/IN-data/toggle back to TransactionSM.
//  Unknown, disabled or (optionally) foreign-address tokens are dropped without any endpoint being selected.
// PARAMETERS
//  NUM_EP       4    endpoint handlers attached, 1..16; EP n sits on bus slice n
//  ACK_TIMEOUT  64   clk48 cycles the selected EP has to assert ep_ack_token before the transaction is abandoned
// PORTS
//  clk48            in   1        single clock, 48 MHz
//  reset            in   1        synchronous, active-high
//  bus_reset        in   1        USB bus reset from TransactionSM
//  pid              in   4        token PID
//  token            in   11       {endp[10:7], addr[6:0]}
//  token_valid      in   1        1-cycle token strobe
//  ack_token        out  1        to TransactionSM: selected EP accepted token
//  out_byte         in   8        host->device data byte
//  out_byte_valid   in   1        byte strobe
//  packet_eop       in   1        end of data packet / transaction
//  packet_ack_code  in   1        handshake code for the completed packet
//  in_byte          out  8        device->host byte from selected EP
//  in_byte_ack      in   1        TransactionSM consumed in_byte
//  in_byte_last     out  1        in_byte is last of packet
//  use_data0        out  1        data toggle of selected EP
//  dev_addr         in   7        current device address (from EP0)
//  ep_enable        in   NUM_EP   per-EP enable; EP0 is enabled regardless of bit 0
//  ep_bus_reset     out  NUM_EP   bus_reset fanned out
//  ep_token_valid   out  NUM_EP   one-hot token strobe; pid/token/out_byte/packet_ack_code are broadcast
//  ep_ack_token     in   NUM_EP   per-EP token accept
//  ep_out_valid     out  NUM_EP   out_byte_valid gated to selected EP
//  ep_eop           out  NUM_EP   packet_eop gated to selected EP
//  ep_in_byte       in   8*NUM_EP per-EP IN data, EP n at [8n+7:8n]
//  ep_in_last       in   NUM_EP   per-EP last flag
//  ep_in_ack        out  NUM_EP   in_byte_ack gated to selected EP
//  ep_use_data0     in   NUM_EP   per-EP toggle
//  cur_ep           out  4        selected endpoint, 0 when idle
//  busy             out  1        state != IDLE
//  err_drop         out  1        1-cycle pulse: token dropped
//  err_timeout      out  1        1-cycle pulse: ACK_TIMEOUT expired
// BEHAVIOUR
//  Reset/bus_reset: state IDLE, cur_ep=0, all outputs 0 except ep_bus_reset (follows bus_reset, 0 during reset).
//  States: IDLE -> WAIT_ACK -> DATA -> IDLE.
//  IDLE: token_valid with pid OUT(0001)/IN(1001)/SETUP(1101): ep=token[10:7]; if ep<NUM_EP and enabled
//   -> latch cur_ep, next cycle ep_token_valid[cur_ep]=1 for exactly 1 cycle, go WAIT_ACK; else err_drop, stay.
//   SOF(0101) and all other PIDs ignored silently (no err_drop).
//  WAIT_ACK: counter from 0; ep_ack_token[cur_ep] -> ack_token registered (1 cycle later, 1-cycle pulse),
//   -> DATA. Counter reaching ACK_TIMEOUT-1 without ack -> err_timeout, IDLE. Acks from other EPs ignored.
//  DATA: out_byte_valid/packet_eop/in_byte_ack routed combinationally to cur_ep only;
//   in_byte/in_byte_last/use_data0 = combinational mux of cur_ep slices (zero added latency on byte path).
//   Exit to IDLE the cycle after packet_eop (any direction). use_data0 stays muxed from cur_ep until IDLE.
//  IDLE/WAIT_ACK: ep_out_valid/ep_eop/ep_in_ack all 0; in_byte=0, in_byte_last=0, use_data0=1.
//  Simultaneous: token_valid in WAIT_ACK/DATA aborts current (no error pulse), token handled as in IDLE
//   same cycle; bus_reset beats everything; token_valid + packet_eop same cycle -> new token wins.
//  Reset mid-transaction: IDLE next cycle, no strobe reaches any EP.
// CONFIGURATION
//  USB_EP_ROUTER_ADDR_FILTER_EN defined: token[6:0] != dev_addr -> token dropped (err_drop pulse).
//  Undefined: address field ignored, dev_addr unused; all address comparison logic absent.
// STRUCTURE
//  usb_pkg: PID constants (PID_OUT/IN/SETUP/SOF), router state encoding, EP number width.
//  Sub-module usb_ep_mux: combinational cur_ep-indexed mux (in_byte/last/toggle) + one-hot demux of strobes.
// TESTING
//  1 SETUP ep0 addr0, ep_ack_token[0] at +3 -> ep_token_valid=0001 1 cycle, ack_token 1 cycle later, 8 bytes only on ep_out_valid[0].
//  2 IN ep1, ep_in_byte[15:8]=A5,last=1 -> in_byte=A5 same cycle, in_byte_ack only on ep_in_ack[1], IDLE after eop.
//  3 OUT ep5 with NUM_EP=4, and OUT ep2 with ep_enable[2]=0 -> err_drop each, no ep_token_valid, busy=0.
//  4 IN ep1 never acked, ACK_TIMEOUT=64 -> err_timeout exactly 64 cycles after ep_token_valid, back IDLE.
//  5 bus_reset during DATA on ep1 -> ep_bus_reset=all ones, state IDLE next cycle, stray bytes not forwarded.
//  6 ADDR_FILTER_EN, dev_addr=0x12: token addr 0x13 -> err_drop; addr 0x12 -> routed normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint router: token PIDs, router states, endpoint number width.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    localparam int unsigned EP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_DATA
    } router_state_t;

    // SOF shares the token PID format but never opens a transaction.
    function automatic logic is_token_pid(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: return 1'b1;
            PID_SOF:                    return 1'b0;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usb_ep_mux.sv
// Endpoint-indexed datapath: muxes IN data/last/toggle/ack from the selected endpoint
// and steers the token, byte, eop and in-ack strobes to that endpoint only.
module usb_ep_mux
    import usb_pkg::*;
#(
    parameter int unsigned NUM_EP = 4
) (
    input  logic [EP_W-1:0]     sel,
    input  logic                route,
    input  logic                tok,
    input  logic                out_byte_valid,
    input  logic                packet_eop,
    input  logic                in_byte_ack,
    input  logic [8*NUM_EP-1:0] ep_in_byte,
    input  logic [NUM_EP-1:0]   ep_in_last,
    input  logic [NUM_EP-1:0]   ep_use_data0,
    input  logic [NUM_EP-1:0]   ep_ack_token,
    output logic [7:0]          in_byte,
    output logic                in_byte_last,
    output logic                use_data0,
    output logic                ack_sel,
    output logic [NUM_EP-1:0]   ep_token_valid,
    output logic [NUM_EP-1:0]   ep_out_valid,
    output logic [NUM_EP-1:0]   ep_eop,
    output logic [NUM_EP-1:0]   ep_in_ack
);

    always_comb begin
        in_byte        = '0;
        in_byte_last   = 1'b0;
        use_data0      = 1'b1;
        ack_sel        = 1'b0;
        ep_token_valid = '0;
        ep_out_valid   = '0;
        ep_eop         = '0;
        ep_in_ack      = '0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            if (sel == EP_W'(i)) begin
                ack_sel           = ep_ack_token[i];
                ep_token_valid[i] = tok;
                if (route) begin
                    ep_out_valid[i] = out_byte_valid;
                    ep_eop[i]       = packet_eop;
                    ep_in_ack[i]    = in_byte_ack;
                    in_byte         = ep_in_byte[8*i +: 8];
                    in_byte_last    = ep_in_last[i];
                    use_data0       = ep_use_data0[i];
                end
            end
        end
    end

endmodule

// File: rtl/usb_ep_router.sv
// Transaction router between TransactionSM and NUM_EP endpoint handlers.
// Define USB_EP_ROUTER_ADDR_FILTER_EN to drop tokens whose address differs from dev_addr.
module usb_ep_router
    import usb_pkg::*;
#(
    parameter int unsigned NUM_EP      = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                clk48,
    input  logic                reset,
    input  logic                bus_reset,
    input  logic [3:0]          pid,
    input  logic [10:0]         token,
    input  logic                token_valid,
    output logic                ack_token,
    input  logic [7:0]          out_byte,
    input  logic                out_byte_valid,
    input  logic                packet_eop,
    input  logic                packet_ack_code,
    output logic [7:0]          in_byte,
    input  logic                in_byte_ack,
    output logic                in_byte_last,
    output logic                use_data0,
    input  logic [6:0]          dev_addr,
    input  logic [NUM_EP-1:0]   ep_enable,
    output logic [NUM_EP-1:0]   ep_bus_reset,
    output logic [NUM_EP-1:0]   ep_token_valid,
    input  logic [NUM_EP-1:0]   ep_ack_token,
    output logic [NUM_EP-1:0]   ep_out_valid,
    output logic [NUM_EP-1:0]   ep_eop,
    input  logic [8*NUM_EP-1:0] ep_in_byte,
    input  logic [NUM_EP-1:0]   ep_in_last,
    output logic [NUM_EP-1:0]   ep_in_ack,
    input  logic [NUM_EP-1:0]   ep_use_data0,
    output logic [3:0]          cur_ep,
    output logic                busy,
    output logic                err_drop,
    output logic                err_timeout
);

    localparam int unsigned      CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    router_state_t    state, nstate;
    logic [EP_W-1:0]  cur_q, ncur;
    logic [CNT_W-1:0] cnt, ncnt;
    logic             tok_q, ntok;
    logic             ack_q, nack;
    logic             drop_q, ndrop;
    logic             tmo_q, ntmo;

    logic             kill, route, ack_sel;
    logic             ep_hit, addr_ok, is_tok, accept, reject;
    logic [EP_W-1:0]  tok_ep;

    assign kill   = reset | bus_reset;
    assign tok_ep = token[10:7];
    assign is_tok = is_token_pid(pid);

`ifdef USB_EP_ROUTER_ADDR_FILTER_EN
    logic unused_bits;
    assign addr_ok     = (token[6:0] == dev_addr);
    assign unused_bits = ^{out_byte, packet_ack_code};
`else
    logic unused_bits;
    assign addr_ok     = 1'b1;
    assign unused_bits = ^{out_byte, packet_ack_code, dev_addr, token[6:0]};
`endif

    // EP0 is the control endpoint and can never be disabled.
    always_comb begin
        ep_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            if (tok_ep == EP_W'(i)) ep_hit = (i == 0) || ep_enable[i];
        end
    end

    assign accept = token_valid & is_tok & ep_hit & addr_ok;
    assign reject = token_valid & is_tok & ~(ep_hit & addr_ok);

    // Any token aborts the open transaction and is then decoded exactly as from IDLE.
    always_comb begin
        nstate = state;
        ncur   = cur_q;
        ncnt   = cnt;
        ntok   = 1'b0;
        nack   = 1'b0;
        ndrop  = 1'b0;
        ntmo   = 1'b0;
        if (token_valid) begin
            if (accept) begin
                nstate = ST_WAIT_ACK;
                ncur   = tok_ep;
                ncnt   = '0;
                ntok   = 1'b1;
            end else begin
                nstate = ST_IDLE;
                ncur   = '0;
                ndrop  = reject;
            end
        end else begin
            case (state)
                ST_WAIT_ACK: begin
                    if (ack_sel) begin
                        nstate = ST_DATA;
                        nack   = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        nstate = ST_IDLE;
                        ncur   = '0;
                        ntmo   = 1'b1;
                    end else begin
                        ncnt = cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (packet_eop) begin
                        nstate = ST_IDLE;
                        ncur   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk48) begin
        if (reset || bus_reset) begin
            state  <= ST_IDLE;
            cur_q  <= '0;
            cnt    <= '0;
            tok_q  <= 1'b0;
            ack_q  <= 1'b0;
            drop_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= nstate;
            cur_q  <= ncur;
            cnt    <= ncnt;
            tok_q  <= ntok;
            ack_q  <= nack;
            drop_q <= ndrop;
            tmo_q  <= ntmo;
        end
    end

    // Strobes are squashed in a reset cycle and in the cycle a new token preempts DATA.
    assign route        = (state == ST_DATA) & ~kill & ~token_valid;
    assign ack_token    = ack_q & ~kill;
    assign err_drop     = drop_q & ~kill;
    assign err_timeout  = tmo_q & ~kill;
    assign ep_bus_reset = {NUM_EP{bus_reset & ~reset}};
    assign cur_ep       = cur_q;
    assign busy         = (state != ST_IDLE);

    usb_ep_mux #(
        .NUM_EP(NUM_EP)
    ) u_mux (
        .sel           (cur_q),
        .route         (route),
        .tok           (tok_q & ~kill),
        .out_byte_valid(out_byte_valid),
        .packet_eop    (packet_eop),
        .in_byte_ack   (in_byte_ack),
        .ep_in_byte    (ep_in_byte),
        .ep_in_last    (ep_in_last),
        .ep_use_data0  (ep_use_data0),
        .ep_ack_token  (ep_ack_token),
        .in_byte       (in_byte),
        .in_byte_last  (in_byte_last),
        .use_data0     (use_data0),
        .ack_sel       (ack_sel),
        .ep_token_valid(ep_token_valid),
        .ep_out_valid  (ep_out_valid),
        .ep_eop        (ep_eop),
        .ep_in_ack     (ep_in_ack)
    );

endmodule

// File: tb/tb_usb_ep_router.sv
// Directed, table-driven bench for usb_ep_router (NUM_EP=4, ACK_TIMEOUT=64).
module tb_usb_ep_router;
    import usb_pkg::*;

    typedef struct packed {
        logic        rst, brst;
        logic [3:0]  pid;
        logic [10:0] tok;
        logic        tv, obv, eop, iack;
        logic [3:0]  ack;
    } ins_t;

    typedef struct packed {
        logic       ack;
        logic [3:0] etv, eov, eeop, eiack;
        logic [7:0] ib;
        logic       last, d0;
        logic [3:0] cur;
        logic       busy, drop, tmo;
        logic [3:0] ebr;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    logic        clk48 = 1'b0;
    logic        reset, bus_reset, token_valid, out_byte_valid, packet_eop, packet_ack_code, in_byte_ack;
    logic [3:0]  pid;
    logic [10:0] token;
    logic [7:0]  out_byte;
    logic [6:0]  dev_addr;
    logic [3:0]  ep_enable, ep_ack_token, ep_in_last, ep_use_data0;
    logic [31:0] ep_in_byte;
    logic        ack_token, in_byte_last, use_data0, busy, err_drop, err_timeout;
    logic [7:0]  in_byte;
    logic [3:0]  ep_bus_reset, ep_token_valid, ep_out_valid, ep_eop, ep_in_ack, cur_ep;

    logic [7:0]  ep_bytes [4];
    logic [3:0]  last_cfg, d0_cfg;
    int          errors = 0;
    int          checks = 0;
    vec_t        q[$];

    always #5 clk48 = ~clk48;

    usb_ep_router #(
        .NUM_EP(4),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk48(clk48), .reset(reset), .bus_reset(bus_reset), .pid(pid), .token(token),
        .token_valid(token_valid), .ack_token(ack_token), .out_byte(out_byte),
        .out_byte_valid(out_byte_valid), .packet_eop(packet_eop), .packet_ack_code(packet_ack_code),
        .in_byte(in_byte), .in_byte_ack(in_byte_ack), .in_byte_last(in_byte_last),
        .use_data0(use_data0), .dev_addr(dev_addr), .ep_enable(ep_enable),
        .ep_bus_reset(ep_bus_reset), .ep_token_valid(ep_token_valid), .ep_ack_token(ep_ack_token),
        .ep_out_valid(ep_out_valid), .ep_eop(ep_eop), .ep_in_byte(ep_in_byte),
        .ep_in_last(ep_in_last), .ep_in_ack(ep_in_ack), .ep_use_data0(ep_use_data0),
        .cur_ep(cur_ep), .busy(busy), .err_drop(err_drop), .err_timeout(err_timeout)
    );

    function automatic ins_t none();
        ins_t v = '0;
        return v;
    endfunction

    function automatic ins_t tk(input logic [3:0] p, input logic [3:0] ep, input logic [6:0] a);
        ins_t v = '0;
        v.tv  = 1'b1;
        v.pid = p;
        v.tok = {ep, a};
        return v;
    endfunction

    function automatic ins_t ev(input logic obv, input logic eop, input logic iack, input logic [3:0] ack);
        ins_t v = '0;
        v.obv  = obv;
        v.eop  = eop;
        v.iack = iack;
        v.ack  = ack;
        return v;
    endfunction

    function automatic outs_t o_idle();
        outs_t o = '0;
        o.d0 = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_drop();
        outs_t o = o_idle();
        o.drop = 1'b1;
        return o;
    endfunction

    function automatic outs_t ow(input logic [3:0] cur, input logic [3:0] etv);
        outs_t o = o_idle();
        o.cur  = cur;
        o.busy = 1'b1;
        o.etv  = etv;
        return o;
    endfunction

    // DATA-phase expectation: IN side comes from the bench's own per-EP configuration.
    function automatic outs_t od(input logic ack, input logic [3:0] cur, input logic [3:0] eov,
                                 input logic [3:0] eeop, input logic [3:0] eiack);
        outs_t o = '0;
        o.ack   = ack;
        o.cur   = cur;
        o.busy  = 1'b1;
        o.eov   = eov;
        o.eeop  = eeop;
        o.eiack = eiack;
        o.ib    = ep_bytes[cur[1:0]];
        o.last  = last_cfg[cur[1:0]];
        o.d0    = d0_cfg[cur[1:0]];
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.ack   = ack_token;
        o.etv   = ep_token_valid;
        o.eov   = ep_out_valid;
        o.eeop  = ep_eop;
        o.eiack = ep_in_ack;
        o.ib    = in_byte;
        o.last  = in_byte_last;
        o.d0    = use_data0;
        o.cur   = cur_ep;
        o.busy  = busy;
        o.drop  = err_drop;
        o.tmo   = err_timeout;
        o.ebr   = ep_bus_reset;
        return o;
    endfunction

    task automatic add(input ins_t i, input outs_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        q.push_back(v);
    endtask

    task automatic apply(input ins_t v);
        @(posedge clk48);
        #1;
        reset          = v.rst;
        bus_reset      = v.brst;
        pid            = v.pid;
        token          = v.tok;
        token_valid    = v.tv;
        out_byte_valid = v.obv;
        packet_eop     = v.eop;
        in_byte_ack    = v.iack;
        ep_ack_token   = v.ack;
        #1;
    endtask

    task automatic check_o(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ins_t  v;
        outs_t o;
        logic  early;

        ep_bytes[0] = 8'h11; ep_bytes[1] = 8'hA5; ep_bytes[2] = 8'hC3; ep_bytes[3] = 8'hD4;
        ep_in_byte      = {ep_bytes[3], ep_bytes[2], ep_bytes[1], ep_bytes[0]};
        last_cfg        = 4'b0010;
        d0_cfg          = 4'b0101;
        ep_in_last      = last_cfg;
        ep_use_data0    = d0_cfg;
        ep_enable       = 4'b1010;
        out_byte        = 8'h5A;
        packet_ack_code = 1'b0;
        dev_addr        = 7'h00;
        reset = 1'b1; bus_reset = 1'b1; pid = '0; token = '0; token_valid = 1'b0;
        out_byte_valid = 1'b0; packet_eop = 1'b0; in_byte_ack = 1'b0; ep_ack_token = '0;

        // Reset with bus_reset also high: no bus reset fan-out while reset is asserted.
        v = none(); v.rst = 1'b1; v.brst = 1'b1;
        apply(v);
        apply(v);
        check_v("rst_busy", busy, 0);
        check_v("rst_cur_ep", cur_ep, 0);
        check_v("rst_ep_bus_reset", ep_bus_reset, 0);
        check_v("rst_ep_token_valid", ep_token_valid, 0);
        apply(none());
        check_o("idle_after_reset", sample(), o_idle());

        // SETUP to EP0 (enable bit 0 clear), ack three cycles after the token, 8 OUT bytes.
        add(tk(PID_SETUP, 4'd0, 7'h00), o_idle());
        add(none(), ow(4'd0, 4'b0001));
        add(none(), ow(4'd0, 4'b0000));
        add(ev(1'b0, 1'b0, 1'b0, 4'b0001), ow(4'd0, 4'b0000));
        for (int k = 0; k < 8; k++)
            add(ev(1'b1, 1'b0, 1'b0, 4'b0000), od(k == 0, 4'd0, 4'b0001, 4'b0000, 4'b0000));
        add(ev(1'b0, 1'b1, 1'b0, 4'b0000), od(1'b0, 4'd0, 4'b0000, 4'b0001, 4'b0000));
        add(none(), o_idle());

        // IN to EP1: an EP0 ack is ignored, then EP1 acks; data comes from EP1 with zero latency.
        add(tk(PID_IN, 4'd1, 7'h00), o_idle());
        add(ev(1'b0, 1'b0, 1'b0, 4'b0001), ow(4'd1, 4'b0010));
        add(ev(1'b0, 1'b0, 1'b0, 4'b0010), ow(4'd1, 4'b0000));
        add(ev(1'b0, 1'b0, 1'b1, 4'b0000), od(1'b1, 4'd1, 4'b0000, 4'b0000, 4'b0010));
        add(ev(1'b0, 1'b1, 1'b0, 4'b0000), od(1'b0, 4'd1, 4'b0000, 4'b0010, 4'b0000));
        add(none(), o_idle());

        // Out-of-range EP, disabled EP, then SOF and ACK PIDs that must be ignored silently.
        add(tk(PID_OUT, 4'd5, 7'h00), o_idle());
        add(tk(PID_OUT, 4'd2, 7'h00), o_drop());
        add(tk(PID_SOF, 4'd1, 7'h00), o_drop());
        add(tk(4'b0010, 4'd1, 7'h00), o_idle());
        add(none(), o_idle());

        // New token in DATA together with packet_eop: the new token wins, old EP sees no eop.
        add(tk(PID_OUT, 4'd3, 7'h00), o_idle());
        add(ev(1'b0, 1'b0, 1'b0, 4'b1000), ow(4'd3, 4'b1000));
        add(ev(1'b1, 1'b0, 1'b0, 4'b0000), od(1'b1, 4'd3, 4'b1000, 4'b0000, 4'b0000));
        v = tk(PID_IN, 4'd1, 7'h00); v.eop = 1'b1;
        add(v, ow(4'd3, 4'b0000));
        add(ev(1'b0, 1'b0, 1'b0, 4'b0010), ow(4'd1, 4'b0010));
        add(ev(1'b0, 1'b1, 1'b0, 4'b0000), od(1'b1, 4'd1, 4'b0000, 4'b0010, 4'b0000));
        add(none(), o_idle());

        // bus_reset in DATA on EP1: fan-out to all EPs, strobes blocked, stray bytes dropped.
        add(tk(PID_IN, 4'd1, 7'h00), o_idle());
        add(ev(1'b0, 1'b0, 1'b0, 4'b0010), ow(4'd1, 4'b0010));
        v = ev(1'b1, 1'b0, 1'b1, 4'b0000); v.brst = 1'b1;
        o = ow(4'd1, 4'b0000); o.ebr = 4'b1111;
        add(v, o);
        add(ev(1'b1, 1'b0, 1'b1, 4'b0000), o_idle());
        add(none(), o_idle());

        for (int k = 0; k < q.size(); k++) begin
            apply(q[k].i);
            check_o($sformatf("vec%0d", k), sample(), q[k].o);
        end

        // ACK timeout: pulse lands exactly 64 cycles after the token strobe.
        apply(tk(PID_IN, 4'd1, 7'h00));
        apply(none());
        check_v("tmo_strobe", ep_token_valid, 4'b0010);
        early = 1'b0;
        for (int k = 1; k < 64; k++) begin
            apply(none());
            if (err_timeout || !busy) early = 1'b1;
        end
        check_v("tmo_not_early", early, 0);
        apply(none());
        check_v("tmo_pulse", err_timeout, 1);
        check_v("tmo_idle", busy, 0);
        check_v("tmo_cur_ep", cur_ep, 0);
        apply(none());
        check_v("tmo_one_cycle", err_timeout, 0);

        // Address handling with dev_addr = 0x12.
        dev_addr = 7'h12;
        apply(tk(PID_OUT, 4'd1, 7'h13));
        apply(none());
`ifdef USB_EP_ROUTER_ADDR_FILTER_EN
        check_v("addr_mismatch_drop", err_drop, 1);
        check_v("addr_mismatch_busy", busy, 0);
        check_v("addr_mismatch_etv", ep_token_valid, 0);
`else
        check_v("addr_ignored_drop", err_drop, 0);
        check_v("addr_ignored_busy", busy, 1);
        check_v("addr_ignored_etv", ep_token_valid, 4'b0010);
`endif
        apply(tk(PID_OUT, 4'd1, 7'h12));
        apply(none());
        check_v("addr_match_etv", ep_token_valid, 4'b0010);
        check_v("addr_match_cur", cur_ep, 1);
        check_v("addr_match_drop", err_drop, 0);
        v = none(); v.brst = 1'b1;
        apply(v);
        apply(none());
        check_v("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
